// File: rtl/branch_pkg.sv
// Shared types and constants for the branch mispredict flush controller.
package branch_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlush    = 2'd1,
    StRedirect = 2'd2
  } state_e;

  // Wide enough for the largest legal FlushCycles-1 (14).
  localparam int unsigned FlushCntWidth = 4;

  function automatic logic is_mispredict(input logic valid, input logic pred, input logic act);
    return valid && (pred != act);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_flush_ctrl.sv
// Mispredict recovery: holds flush for FlushCycles, then offers the corrected PC to fetch.
module branch_flush_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned WordSize    = 32,
  parameter int unsigned FlushCycles = 2,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                resolve_valid,
  input  logic                pred_taken,
  input  logic                act_taken,
  input  logic [WordSize-1:0] npc_corr,
  input  logic                redirect_ready,
  output logic                flush,
  output logic                stall_fetch,
  output logic                redirect_valid,
  output logic [WordSize-1:0] redirect_pc,
  output logic                busy,
  output logic [CntWidth-1:0] branch_cnt,
  output logic [CntWidth-1:0] mispred_cnt
);

  localparam logic [FlushCntWidth-1:0] FlushLoad = FlushCntWidth'(FlushCycles - 1);

  state_e                   state_q;
  logic [FlushCntWidth-1:0] flush_cnt_q;
  logic                     accept;
  logic                     accept_mispred;

  // Resolves outside IDLE belong to squashed instructions.
  assign accept         = (state_q == StIdle) && resolve_valid;
  assign accept_mispred = (state_q == StIdle) &&
                          is_mispredict(resolve_valid, pred_taken, act_taken);

  // Outputs are registered alongside the state so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= StIdle;
      flush_cnt_q    <= '0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      stall_fetch    <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept_mispred) begin
            state_q     <= StFlush;
            flush_cnt_q <= FlushLoad;
            redirect_pc <= npc_corr;
            flush       <= 1'b1;
            stall_fetch <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StFlush: begin
          if (flush_cnt_q == '0) begin
            state_q        <= StRedirect;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - FlushCntWidth'(1);
          end
        end
        StRedirect: begin
          if (redirect_ready) begin
            state_q        <= StIdle;
            redirect_valid <= 1'b0;
            stall_fetch    <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: begin
          state_q        <= StIdle;
          flush          <= 1'b0;
          stall_fetch    <= 1'b0;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .Width (CntWidth)
  ) u_branch_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (accept),
    .count (branch_cnt)
  );

  sat_counter #(
    .Width (CntWidth)
  ) u_mispred_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (accept_mispred),
    .count (mispred_cnt)
  );

endmodule

// File: doc/branch_flush_ctrl.md
BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 - WordSize, 32, PC/address width.
 - FlushCycles, 2, cycles flush is held after a mispredict; legal range 1..15.
 - CntWidth, 16, width of the statistics counters.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 - clk, in, 1, sole clock; all state updates on its rising edge.
 - rstn, in, 1, reset, synchronous, active-low.
 - resolve_valid, in, 1, a branch resolves this cycle.
 - pred_taken, in, 1, predicted direction of the resolving branch.
 - act_taken, in, 1, evaluated direction of the resolving branch.
 - npc_corr, in, WordSize, corrected next PC for the resolving branch.
 - redirect_ready, in, 1, fetch accepts the redirect.
 - flush, out, 1, squash younger pipeline stages.
 - stall_fetch, out, 1, fetch shall not advance.
 - redirect_valid, out, 1, redirect_pc is valid.
 - redirect_pc, out, WordSize, PC for fetch to restart from.
 - busy, out, 1, controller is not IDLE.
 - branch_cnt, out, CntWidth, count of accepted resolves.
 - mispred_cnt, out, CntWidth, count of accepted mispredicts.

Function
REQ-003 A mispredict SHALL be defined as resolve_valid=1 and pred_taken!=act_taken.
REQ-004 The FSM SHALL have exactly three states: IDLE, FLUSH, REDIRECT.
REQ-005 A resolve SHALL be accepted only in IDLE; resolves in FLUSH or REDIRECT come from squashed instructions and SHALL be ignored, with no counter or state effect.
REQ-006 IDLE to FLUSH SHALL occur on an accepted mispredict, capturing npc_corr into redirect_pc and loading the flush counter with FlushCycles-1.
REQ-007 In FLUSH: flush=1; the counter decrements each cycle; at 0 the FSM SHALL go to REDIRECT. Flush is therefore high exactly FlushCycles cycles, starting the cycle after detection.
REQ-008 In REDIRECT: redirect_valid=1, flush=0. redirect_pc SHALL stay stable while redirect_ready=0. When redirect_ready=1 the FSM SHALL return to IDLE, with redirect_valid low the next cycle.
REQ-009 stall_fetch and busy SHALL be 1 in FLUSH and REDIRECT and 0 in IDLE.
REQ-010 A correctly predicted resolve in IDLE SHALL only increment branch_cnt; the state SHALL remain IDLE.
REQ-011 branch_cnt SHALL increment on every accepted resolve; mispred_cnt SHALL increment on every accepted mispredict.
REQ-012 Both counters SHALL saturate at 2^CntWidth-1 and never wrap.
REQ-013 Combinational paths SHALL NOT run from inputs to outputs; all outputs are registered or decoded from state only.
REQ-014 A mispredict in the cycle immediately after the redirect handshake (state IDLE) SHALL be accepted normally.
REQ-015 redirect_ready asserted outside REDIRECT SHALL be ignored.

Reset
REQ-016 While rstn=0 at a clk edge, the block SHALL enter IDLE, and flush, stall_fetch, redirect_valid, busy, redirect_pc, branch_cnt, mispred_cnt and the flush counter SHALL all be 0.
REQ-017 Reset asserted in FLUSH or REDIRECT SHALL abandon the pending redirect; no redirect_valid pulse follows reset release.
REQ-018 In the first cycle after release, inputs SHALL be sampled normally.

Structure
REQ-019 A shared package branch_pkg SHALL hold the state enum typedef (IDLE, FLUSH, REDIRECT) and the flush-counter width constant (4 bits).
REQ-020 Counting SHALL use one sub-module, sat_counter (parameter Width; inputs clk, rstn, inc; output count), instantiated twice.
REQ-021 The expected implementation size is 120-400 RTL lines, including sat_counter.

Verification (FlushCycles=2, CntWidth=16, WordSize=32)
REQ-022 Reset, then 3 correctly predicted resolves -> branch_cnt=3, mispred_cnt=0, flush never asserts, busy=0 throughout.
REQ-023 Mispredict at cycle 10, npc_corr=0x0000_0400, redirect_ready=1 -> flush=1 in cycles 11-12; redirect_valid=1 with redirect_pc=0x400 in cycle 13; IDLE in cycle 14; mispred_cnt=1.
REQ-024 Same mispredict with redirect_ready held 0 for 4 cycles -> redirect_valid and redirect_pc=0x400 stable for 5 cycles; stall_fetch=1 throughout.
REQ-025 Mispredicts with npc_corr=0x800 injected during FLUSH and REDIRECT -> ignored: redirect_pc stays 0x400, counters unchanged.
REQ-026 rstn=0 for 1 cycle during FLUSH -> next cycle all outputs 0 and state IDLE; no redirect follows.
REQ-027 Preload branch_cnt to 0xFFFE (force), then 3 resolves -> branch_cnt=0xFFFF with no wrap.
